memory_arbiter: RTL

- Sits directly upstream of the RAM slave.
- Multiplexes NUM_MASTERS requesters (I-cache, D-cache, DMA) onto the single MemoryInterface slave port, using round-robin arbitration.
- Holds the granted master's request stable until the RAM raises functionComplete.
- Then forces one idle cycle so the RAM's delay counter reloads before the next access.

---
 rtl/memory_arbiter_pkg.sv | 14 +
 rtl/memory_arbiter_round_robin_picker.sv | 31 +++
 rtl/memory_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared state encodings and helpers for the memory arbiter.
package memory_arbiter_pkg;

   // Arbiter FSM states.
   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StBusy    = 2'd1;
   localparam logic [1:0] StRelease = 2'd2;

   // Advance a master index by one, wrapping n-1 back to 0.
   function automatic int next_index(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/memory_arbiter_round_robin_picker.sv
// Combinational round-robin picker: first requester at or after the pointer.
module round_robin_picker
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS        = 2,
   parameter int unsigned MASTER_INDEX_WIDTH = 1
) (
   input  logic [NUM_MASTERS-1:0]        request,
   input  logic [MASTER_INDEX_WIDTH-1:0] pointer,
   output logic [MASTER_INDEX_WIDTH-1:0] grant,
   output logic                          anyRequest
);

   // Scan requesters starting at the pointer, taking the first one found.
   always_comb begin
      int   idx;
      logic found;
      grant = pointer;
      found = 1'b0;
      idx   = int'(pointer);
      for (int k = 0; k < int'(NUM_MASTERS); k++) begin
         if (!found && request[MASTER_INDEX_WIDTH'(idx)]) begin
            grant = MASTER_INDEX_WIDTH'(idx);
            found = 1'b1;
         end
         idx = next_index(idx, int'(NUM_MASTERS));
      end
      anyRequest = |request;
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter multiplexing several masters onto one RAM slave port.
// Each access is followed by one forced idle cycle so the RAM delay counter reloads.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS        = 2,
   parameter int unsigned ADDRESS_WIDTH      = 16,
   parameter int unsigned DATA_WIDTH         = 32,
   parameter int unsigned MASTER_INDEX_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] masterAddress,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    masterDataOut,
   input  logic [NUM_MASTERS-1:0]               masterReadEnabled,
   input  logic [NUM_MASTERS-1:0]               masterWriteEnabled,
   output logic [DATA_WIDTH-1:0]                masterDataIn,
   output logic [NUM_MASTERS-1:0]               masterFunctionComplete,
   output logic [ADDRESS_WIDTH-1:0]             slaveAddress,
   output logic [DATA_WIDTH-1:0]                slaveDataOut,
   output logic                                 slaveReadEnabled,
   output logic                                 slaveWriteEnabled,
   input  logic [DATA_WIDTH-1:0]                slaveDataIn,
   input  logic                                 slaveFunctionComplete
);

   logic [1:0]                    state_q, state_d;
   logic [MASTER_INDEX_WIDTH-1:0] grant_q, grant_d;
   logic [MASTER_INDEX_WIDTH-1:0] pointer_q, pointer_d;
   logic [MASTER_INDEX_WIDTH-1:0] pickGrant;
   logic                          anyRequest;
   logic [NUM_MASTERS-1:0]        request;
   logic [ADDRESS_WIDTH-1:0]      grantAddress;
   logic [DATA_WIDTH-1:0]         grantData;
   logic                          grantRead;
   logic                          grantWrite;
   logic                          grantRequest;

   assign request      = masterReadEnabled | masterWriteEnabled;
   assign grantRequest = grantRead | grantWrite;
   assign masterDataIn = slaveDataIn;

   round_robin_picker #(
      .NUM_MASTERS       (NUM_MASTERS),
      .MASTER_INDEX_WIDTH(MASTER_INDEX_WIDTH)
   ) u_picker (
      .request   (request),
      .pointer   (pointer_q),
      .grant     (pickGrant),
      .anyRequest(anyRequest)
   );

   // Select the granted master's request fields.
   always_comb begin
      grantAddress = '0;
      grantData    = '0;
      grantRead    = 1'b0;
      grantWrite   = 1'b0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         if (grant_q == MASTER_INDEX_WIDTH'(i)) begin
            grantAddress = masterAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            grantData    = masterDataOut[i*DATA_WIDTH +: DATA_WIDTH];
            grantRead    = masterReadEnabled[i];
            grantWrite   = masterWriteEnabled[i];
         end
      end
   end

   // Slave port and completion outputs; the slave is only driven while busy.
   always_comb begin
      slaveAddress           = '0;
      slaveDataOut           = '0;
      slaveReadEnabled       = 1'b0;
      slaveWriteEnabled      = 1'b0;
      masterFunctionComplete = '0;
      if (state_q == StBusy) begin
         slaveAddress      = grantAddress;
         slaveDataOut      = grantData;
         // Write wins when a master raises both enables.
         slaveWriteEnabled = grantWrite;
         slaveReadEnabled  = grantRead & ~grantWrite;
         masterFunctionComplete[grant_q] = slaveFunctionComplete & grantRequest;
      end
   end

   // Next-state logic: arbitrate in idle, hold grant while busy, one release cycle.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      pointer_d = pointer_q;
      case (state_q)
         StIdle: begin
            if (anyRequest) begin
               grant_d = pickGrant;
               state_d = StBusy;
            end
         end
         StBusy: begin
            // Completion or master abort both end the access and advance the pointer.
            if (!grantRequest || slaveFunctionComplete) begin
               state_d   = StRelease;
               pointer_d = MASTER_INDEX_WIDTH'(next_index(int'(grant_q), int'(NUM_MASTERS)));
            end
         end
         StRelease: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         pointer_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         pointer_q <= pointer_d;
      end
   end

endmodule
